// File: rtl/sim_run_pkg.sv
// sim_run_pkg: shared states and constants for the regression run controller
package sim_run_pkg;
  typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} run_state_e;
  localparam int TOHOST_PASS_VAL = 1;
  localparam int EXIT_SHIFT = 1;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt
);
  // clear has priority; increment only below all-ones
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/sim_run_controller.sv
// sim_run_controller: sequences core reset, counts a run and reports its tohost/timeout result
module sim_run_controller import sim_run_pkg::*; #(
  parameter int                XLEN         = 32,
  parameter int                ADDR_W       = 32,
  parameter int                CNT_W        = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h100,
  parameter int                RST_CYCLES   = 1,
  parameter int                DRAIN_CYCLES = 4,
  parameter int                MAX_CYCLES   = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  input  logic              retire,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [XLEN-1:0]   exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);
  localparam int PW = $clog2(max_int(RST_CYCLES, DRAIN_CYCLES) + 1);
  localparam logic [PW-1:0] RST_LAST = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
  run_state_e state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic go, hit, tmo, in_run;
  assign in_run = state == RUN;
  assign go = start && (state == IDLE || state == DONE);
  assign hit = in_run && dm_we && dm_addr == TOHOST_ADDR;
  assign tmo = in_run && !hit && MAX_CYCLES != 0 && cycle_count == CNT_W'(MAX_CYCLES - 1);
  assign core_rst = state == IDLE || state == RESET || state == DONE;
  assign running = state == RUN || state == DRAIN;
  assign done = state == DONE;
  // state and phase registers; reset aborts any run back to IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  // next state: phase counts cycles spent in RESET and DRAIN
  always_comb begin
    state_n = state;
    phase_n = phase;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = RESET;
        phase_n = '0;
      end
      RESET: if (phase == RST_LAST) begin
        state_n = RUN;
        phase_n = '0;
      end else phase_n = phase + 1'b1;
      RUN: if (hit || tmo) begin
        state_n = DRAIN_CYCLES == 0 ? DONE : DRAIN;
        phase_n = '0;
      end
      DRAIN: if (phase == DRAIN_LAST) state_n = DONE;
      else phase_n = phase + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // results cleared on an accepted start, captured once when the run ends
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pass <= 1'b0;
      timeout <= 1'b0;
      exit_code <= '0;
    end else if (go) begin
      pass <= 1'b0;
      timeout <= 1'b0;
      exit_code <= '0;
    end else if (hit) begin
      pass <= dm_wdata == XLEN'(TOHOST_PASS_VAL);
      timeout <= 1'b0;
      exit_code <= dm_wdata >> EXIT_SHIFT;
    end else if (tmo) begin
      pass <= 1'b0;
      timeout <= 1'b1;
      exit_code <= '0;
    end
  sat_counter #(.W(CNT_W)) u_cycles (
    .clk(clk), .rst(rst), .clear(go), .en(in_run), .cnt(cycle_count)
  );
  sat_counter #(.W(CNT_W)) u_instret (
    .clk(clk), .rst(rst), .clear(go), .en(in_run && retire), .cnt(instret_count)
  );
endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: scoreboard bench for run sequencing, halt, timeout and abort
module tb_sim_run_controller;
  logic clk = 0, rst = 0, start = 0, dm_we = 0, retire = 0;
  logic [31:0] dm_addr = 0, dm_wdata = 0;
  logic core_rst, running, done, pass, timeout;
  logic [31:0] exit_code, cycle_count, instret_count;
  int checks = 0, errors = 0;
  typedef struct {
    logic p;
    logic t;
    logic [31:0] e;
    logic [31:0] c;
    logic [31:0] i;
  } res_t;
  res_t sb[$];
  sim_run_controller dut (
    .clk(clk), .rst(rst), .start(start), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .retire(retire), .core_rst(core_rst), .running(running),
    .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clr_in();
    dm_we = 0; dm_addr = 0; dm_wdata = 0; retire = 0; start = 0;
  endtask
  task automatic run(input int halt, input logic [31:0] val, input int nret, input bit poke);
    res_t r, o;
    int last, d;
    last = halt != 0 ? halt : 100;
    r.p = halt != 0 && val == 1;
    r.t = halt == 0;
    r.e = halt != 0 ? val >> 1 : 0;
    r.c = last;
    r.i = nret;
    sb.push_back(r);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check("rst_hold", {running, core_rst, done}, 3'b010);
    check("clr_cnt", {cycle_count, instret_count}, 0);
    check("clr_res", {pass, timeout, exit_code}, 0);
    @(negedge clk);
    check("run_entry", {running, core_rst}, 2'b10);
    for (int k = 1; k <= last; k++) begin
      retire = k <= nret;
      dm_we = k == halt || k == 3;
      dm_addr = k == halt ? 32'h100 : 32'h104;
      dm_wdata = k == halt ? val : 32'd1;
      start = poke && k == 5;
      @(negedge clk);
    end
    check("drain_run", {running, done}, 2'b10);
    check("drain_cyc", cycle_count, last);
    dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'd7; retire = 1;
    d = 0;
    while (!done && d < 20) begin
      d++;
      @(negedge clk);
      clr_in();
    end
    check("drain_len", d, 4);
    check("done_flags", {done, running, core_rst}, 3'b101);
    repeat (2) @(negedge clk);
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      o = sb.pop_front();
      check("pass", pass, o.p);
      check("timeout", timeout, o.t);
      check("exit_code", exit_code, o.e);
      check("cycles", cycle_count, o.c);
      check("instret", instret_count, o.i);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    #2;
    check("rst_async", {core_rst, running, done, pass, timeout}, 5'b10000);
    check("rst_cnt", {cycle_count, instret_count, exit_code}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    check("idle", {core_rst, running, done}, 3'b100);
    run(20, 32'd1, 15, 0);
    run(30, 32'd7, 12, 0);
    run(0, 32'd0, 40, 0);
    run(100, 32'd1, 50, 0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    for (int k = 1; k < 10; k++) begin
      retire = 1;
      @(negedge clk);
    end
    check("pre_abort", {cycle_count, instret_count}, {32'd9, 32'd9});
    rst = 0;
    #1;
    check("abort_ctl", {core_rst, running, done}, 3'b100);
    check("abort_cnt", {cycle_count, instret_count}, 0);
    retire = 0; start = 1;
    @(negedge clk); start = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("start_in_rst", {core_rst, running}, 2'b10);
    run(20, 32'd1, 15, 1);
    run(20, 32'd1, 15, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
